// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment table, blank constant and output polarity helpers for display_scan_7s
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high segment codes, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

    function automatic logic bit_pol(input logic b, input bit active_low);
        return active_low ? ~b : b;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-high 7-segment code
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/display_scan_7s.sv
// rtl/display_scan_7s.sv - multiplexed N-digit 7-segment scanner with tear-free frame
// updates, leading-zero blanking, PWM brightness and anti-ghost dead time
module display_scan_7s
    import display_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   X,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [6:0]              D,
    output logic                    DP,
    output logic [N_DIGITS-1:0]     An,
    output logic                    tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam bit AL = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

    logic [PW-1:0]                 presc;
    logic [IW-1:0]                 idx;
    logic [BRIGHT_W-1:0]           pwm;
    logic                          pend;
    logic [N_DIGITS-1:0][3:0]      pend_x;
    logic [N_DIGITS-1:0][3:0]      shadow_x;
    logic [N_DIGITS-1:0]           pend_dp;
    logic [N_DIGITS-1:0]           shadow_dp;
    logic                          tick_c;
    logic                          wrap;
    logic                          zero_run;
    logic [N_DIGITS-1:0]           lz_mask;
    logic [6:0]                    cur_seg;
    logic                          pwm_en;
    logic [N_DIGITS-1:0]           an_act;

    assign tick_c = (presc == PRESC_MAX);
    assign tick   = tick_c;
    assign wrap   = tick_c && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            pwm   <= '0;
        end else begin
            presc <= tick_c ? '0 : presc + PW'(1);
            pwm   <= pwm + BRIGHT_W'(1);
            if (tick_c) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end
        end
    end

    // Shadow only moves on the frame-wrap edge, so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_x    <= '0;
            pend_dp   <= '0;
            shadow_x  <= '0;
            shadow_dp <= '0;
        end else if (wrap) begin
            pend <= 1'b0;
            if (load) begin
                shadow_x  <= X;
                shadow_dp <= dp;
            end else if (pend) begin
                shadow_x  <= pend_x;
                shadow_dp <= pend_dp;
            end
        end else if (load) begin
            pend    <= 1'b1;
            pend_x  <= X;
            pend_dp <= dp;
        end
    end

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (shadow_x[k] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    seg7_decode u_dec (
        .nib (shadow_x[idx]),
        .seg (cur_seg)
    );

    assign pwm_en = (pwm < bright) || (&bright);

    // Registering a dark An on the tick edge leaves the first cycle of each slot unlit.
    always_comb begin
        an_act = '0;
        if (pwm_en && !(blank_lz && lz_mask[idx]) && !tick_c) begin
            an_act[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D  <= seg_pol(SEG_OFF, AL);
            DP <= bit_pol(1'b0, AL);
            An <= AL ? '1 : '0;
        end else begin
            D  <= seg_pol(cur_seg, AL);
            DP <= bit_pol(shadow_dp[idx], AL);
            An <= AL ? ~an_act : an_act;
        end
    end

endmodule

// File: doc/display_scan_7s.md
# display_scan_7s

Parametrised multiplexed 7-segment display scanner; next-generation replacement for the fixed 4-digit displayer. Drives N common-anode/cathode digits from a packed hex word with per-digit decimal points, leading-zero blanking, PWM brightness, anti-ghost dead time and tear-free frame updates. Sits between datapath/status logic and board display pins.

## Interface
Parameters:
- N_DIGITS, 4, number of digits (>=1)
- CLK_DIV, 50000, clk cycles per digit slot (>=2)
- BRIGHT_W, 4, brightness control width
- ACTIVE_LOW, 1, 1 = D, DP, An active-low; 0 = active-high

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- X  in  4*N_DIGITS  hex value; X[4k+3:4k] = digit k, digit 0 rightmost
- dp  in  N_DIGITS  decimal point per digit, 1 = lit
- load  in  1  capture X/dp for display
- blank_lz  in  1  enable leading-zero blanking
- bright  in  BRIGHT_W  brightness level
- D  out  7  segments, D[0]=a … D[6]=g, registered
- DP  out  1  decimal point, registered
- An  out  N_DIGITS  digit enables, one-hot active, registered
- tick  out  1  one-cycle slot strobe

## Operation
- Prescaler 0..CLK_DIV-1, wraps; tick = 1 when prescaler == CLK_DIV-1.
- Digit index idx 0..N_DIGITS-1, increments on tick, wraps N_DIGITS-1 -> 0 (frame wrap).
- load: X, dp captured into pending regs, pend flag set. Multiple loads before wrap: last wins.
- Frame-wrap tick with pend set: shadow <= pending, pend cleared. load coincident with wrap tick: X/dp go directly into shadow, pend cleared.
- Display always from shadow; no digit changes mid-frame.
- Leading-zero blanking (blank_lz=1): digit k blanked if shadow nibbles k..N_DIGITS-1 are all zero; digit 0 never blanked. Blanked digit: An inactive for its slot.
- Decoder: hex 0–F, active-high codes 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; inverted when ACTIVE_LOW.
- PWM: free-running BRIGHT_W-bit counter pwm; enable = (pwm < bright) or (bright == all ones). bright = 0 -> display dark.
- An[idx] active only when enable, not blanked, not dead time; other An bits inactive. D/DP always reflect digit idx.

## Timing
- Reset (async): D, DP, An all inactive (ACTIVE_LOW=1: D=7'h7F, DP=1, An=all ones); prescaler, idx, pwm, pend, pending, shadow = 0; tick=0.
- First tick at cycle CLK_DIV-1 after reset release.
- Outputs registered: D/DP/An reflect idx/pwm of previous cycle (1-cycle latency).
- Dead time: An forced inactive in the first output cycle of every slot (cycle after tick).
- load to visible: at most N_DIGITS*CLK_DIV + 1 cycles.
- rst_n asserted mid-frame: outputs inactive immediately, pending load discarded.

## Structure
- Package display_pkg: 16-entry segment table / hex_to_seg function, SEG_OFF constant, ACTIVE_LOW polarity helper.
- Sub-module seg7_decode (combinational nibble -> 7 segments, active-high); polarity applied in top-level output register.
- Widths: prescaler $clog2(CLK_DIV), idx max(1,$clog2(N_DIGITS)).

## Test plan
Bench params N_DIGITS=4, CLK_DIV=4, BRIGHT_W=2, ACTIVE_LOW=1, bright=3 unless stated.
- Reset: hold rst_n=0 -> An=4'hF, D=7'h7F, DP=1; release -> tick first high at cycle 3, then every 4 cycles.
- Load X=16'h12AF, dp=4'b0001: after wrap, slot 0 D=7'h0E, DP=0; slot 3 D=7'h79; slot 1 D=7'h08; An[k]=0 except dead cycle.
- Leading zeros, blank_lz=1: X=16'h0030 -> An[3], An[2] never low; digit 1 D=7'h30, digit 0 D=7'h40. X=0 -> only An[0] ever low.
- Tear-free: load 16'h5555 at idx=1 over 16'h1234 -> digits 2,3 still show 2,1 this frame; all show 5 from next idx 0. Load on wrap-tick cycle -> new value in that frame.
- Brightness: bright=0 -> An stays 4'hF; bright=1 -> An[idx] low 1 of every 4 cycles; bright=3 -> low all non-dead cycles.
- Async reset mid-frame at idx=2 -> An=4'hF same cycle, idx restarts at 0, pending load lost.
